// File: rtl/sap_pkg.sv
// Shared types and constants for the SAP OBI external-master arbiter.
//   - OBI request/response structs used on every manager and subordinate port
//   - default arbiter sizing (number of managers, outstanding depth)
//   - requester index type and control FSM state encoding
package sap_pkg;

  localparam int SAP_ARB_NREQ      = 2;
  localparam int SAP_ARB_MAX_OUTST = 4;

  typedef logic [$clog2(SAP_ARB_NREQ)-1:0] sap_arb_idx_t;

  typedef struct packed {
    logic        req;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
  } sap_obi_req_t;

  typedef struct packed {
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
  } sap_obi_resp_t;

  typedef enum logic {
    ARB_ST  = 1'b0,
    HOLD_ST = 1'b1
  } sap_arb_state_e;

  // Index width for n requesters; a single requester still needs one bit.
  function automatic int sap_arb_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sap_arb_order_fifo.sv
// Response-order FIFO: remembers which requester owns each outstanding
// transaction so responses can be routed back in issue order.
// Ports:
//   clk_i, rst_ni  clock, synchronous active-low reset (empties the FIFO)
//   push, push_idx write requester index at the tail
//   pop            drop the head entry
//   head           requester index at the head
//   full, empty    occupancy flags from the registered count
module sap_arb_order_fifo
  import sap_pkg::*;
#(
  parameter int DEPTH = SAP_ARB_MAX_OUTST,
  parameter int IW    = $bits(sap_arb_idx_t)
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          push,
  input  logic [IW-1:0] push_idx,
  input  logic          pop,
  output logic [IW-1:0] head,
  output logic          full,
  output logic          empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [IW-1:0] mem [DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q;

  // Power-of-two depth lets the pointers wrap by plain overflow.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) mem[wr_ptr_q] <= push_idx;
  end

  assign head  = mem[rd_ptr_q];
  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);

endmodule

// File: rtl/sap_obi_ext_arbiter.sv
// Round-robin arbiter sharing the sap_top OBI external-master port between
// NREQ OBI managers. One address phase is forwarded at a time with no added
// latency; responses are routed back by an order FIFO.
// Ports:
//   clk_i, rst_ni  clock, synchronous active-low reset
//   slv_req_i      requests from the managers
//   slv_resp_o     gnt/rvalid/rdata back to the managers
//   mst_req_o      request to sap_top ext_master_req_i
//   mst_resp_i     response from sap_top ext_master_resp_o
//   err_o          sticky: rvalid arrived with nothing outstanding
//   gnt_cnt_o      per-requester handshake counters (SAP_ARB_PERF_CNT_EN only)
// Optional feature macro: SAP_ARB_PERF_CNT_EN
//
// state   | meaning
// ARB_ST  | no stalled address phase; pick by round-robin from rr_ptr
// HOLD_ST | address phase issued but not granted; selection locked
module sap_obi_ext_arbiter
  import sap_pkg::*;
#(
  parameter int  NREQ            = SAP_ARB_NREQ,
  parameter int  MAX_OUTSTANDING = SAP_ARB_MAX_OUTST,
  parameter type obi_req_t       = sap_obi_req_t,
  parameter type obi_resp_t      = sap_obi_resp_t
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  obi_req_t    slv_req_i  [NREQ],
  output obi_resp_t   slv_resp_o [NREQ],
  output obi_req_t    mst_req_o,
  input  obi_resp_t   mst_resp_i,
  output logic        err_o
`ifdef SAP_ARB_PERF_CNT_EN
  ,
  output logic [31:0] gnt_cnt_o  [NREQ]
`endif
);

  localparam int IW = sap_arb_idx_w(NREQ);
  typedef logic [IW-1:0] idx_t;

  sap_arb_state_e state_q, state_d;
  idx_t rr_ptr_q, lock_idx_q;
  idx_t search_idx, cand, sel, head;
  logic fwd_req, hs, pop, fifo_full, fifo_empty, err_q;

  // Walk downward so the last hit is the one closest to rr_ptr.
  always_comb begin
    search_idx = rr_ptr_q;
    cand       = rr_ptr_q;
    for (int k = NREQ - 1; k >= 0; k--) begin
      cand = idx_t'((int'(rr_ptr_q) + k) % NREQ);
      if (slv_req_i[cand].req) search_idx = cand;
    end
  end

  assign sel     = (state_q == HOLD_ST) ? lock_idx_q : search_idx;
  assign fwd_req = rst_ni & ~fifo_full & slv_req_i[sel].req;
  assign hs      = fwd_req & mst_resp_i.gnt;
  assign pop     = rst_ni & mst_resp_i.rvalid & ~fifo_empty;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) state_q <= ARB_ST;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ARB_ST:  if (fwd_req && !mst_resp_i.gnt) state_d = HOLD_ST;
      HOLD_ST: if (hs)                         state_d = ARB_ST;
      default:                                 state_d = ARB_ST;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rr_ptr_q   <= '0;
      lock_idx_q <= '0;
      err_q      <= 1'b0;
    end else begin
      if (state_q == ARB_ST && fwd_req && !mst_resp_i.gnt) lock_idx_q <= sel;
      if (hs) rr_ptr_q <= (sel == idx_t'(NREQ - 1)) ? '0 : sel + 1'b1;
      if (mst_resp_i.rvalid && fifo_empty) err_q <= 1'b1;
    end
  end

  always_comb begin
    mst_req_o     = slv_req_i[sel];
    mst_req_o.req = fwd_req;
    for (int i = 0; i < NREQ; i++) slv_resp_o[i] = '0;
    slv_resp_o[sel].gnt = hs;
    if (pop) begin
      slv_resp_o[head].rvalid = 1'b1;
      slv_resp_o[head].rdata  = mst_resp_i.rdata;
    end
  end

  assign err_o = err_q;

  sap_arb_order_fifo #(
    .DEPTH (MAX_OUTSTANDING),
    .IW    (IW)
  ) u_order_fifo (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .push     (hs),
    .push_idx (sel),
    .pop      (pop),
    .head     (head),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

`ifdef SAP_ARB_PERF_CNT_EN
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int i = 0; i < NREQ; i++) gnt_cnt_o[i] <= '0;
    end else if (hs) begin
      gnt_cnt_o[sel] <= gnt_cnt_o[sel] + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_sap_obi_ext_arbiter.sv
// Self-checking bench for sap_obi_ext_arbiter: directed scenarios plus a
// randomized run checked against a queue-based reference model.
module tb_sap_obi_ext_arbiter;
  import sap_pkg::*;

  localparam int NREQ = 2;
  localparam int MAXO = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  sap_obi_req_t  slv_req  [NREQ];
  sap_obi_resp_t slv_resp [NREQ];
  sap_obi_req_t  mst_req;
  sap_obi_resp_t mst_resp;
  logic          err;
`ifdef SAP_ARB_PERF_CNT_EN
  logic [31:0]   gnt_cnt  [NREQ];
`endif

  int n_cmp = 0;
  int n_err = 0;

  // reference model state
  int          m_rr;
  bit          m_lock;
  int          m_lock_idx;
  int          m_q[$];
  bit          m_err;
  logic [31:0] m_cnt [NREQ];

  always #5 clk = ~clk;

  sap_obi_ext_arbiter #(.NREQ(NREQ), .MAX_OUTSTANDING(MAXO)) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .slv_req_i  (slv_req),
    .slv_resp_o (slv_resp),
    .mst_req_o  (mst_req),
    .mst_resp_i (mst_resp),
    .err_o      (err)
`ifdef SAP_ARB_PERF_CNT_EN
    ,
    .gnt_cnt_o  (gnt_cnt)
`endif
  );

  function automatic int m_sel();
    if (m_lock) return m_lock_idx;
    for (int k = 0; k < NREQ; k++) begin
      if (slv_req[(m_rr + k) % NREQ].req) return (m_rr + k) % NREQ;
    end
    return -1;
  endfunction

  function automatic bit m_mreq();
    int s;
    s = m_sel();
    return rst_n && (s >= 0) && slv_req[s].req && (m_q.size() < MAXO);
  endfunction

  function automatic bit exp_gnt(input int i);
    return m_mreq() && (m_sel() == i) && mst_resp.gnt;
  endfunction

  function automatic bit exp_rv(input int i);
    return rst_n && mst_resp.rvalid && (m_q.size() > 0) && (m_q[0] == i);
  endfunction

  task automatic model_step();
    int s;
    bit fwd, hs;
    if (!rst_n) begin
      m_rr = 0; m_lock = 0; m_lock_idx = 0; m_err = 0; m_q.delete();
      for (int i = 0; i < NREQ; i++) m_cnt[i] = '0;
    end else begin
      s   = m_sel();
      fwd = m_mreq();
      hs  = fwd && mst_resp.gnt;
      if (mst_resp.rvalid) begin
        if (m_q.size() == 0) m_err = 1;
        else void'(m_q.pop_front());
      end
      if (hs) begin
        m_q.push_back(s);
        m_rr = (s + 1) % NREQ;
        m_lock = 0;
        m_cnt[s] = m_cnt[s] + 32'd1;
      end else if (fwd) begin
        m_lock = 1;
        m_lock_idx = s;
      end
    end
  endtask

  task automatic clk_step();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic drive_idle();
    for (int i = 0; i < NREQ; i++) slv_req[i] = '0;
    mst_resp = '0;
  endtask

  task automatic set_req(input int i, input logic we, input logic [31:0] addr, input logic [31:0] wdata);
    slv_req[i].req = 1'b1; slv_req[i].we = we; slv_req[i].be = 4'hF;
    slv_req[i].addr = addr; slv_req[i].wdata = wdata;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    drive_idle();
    clk_step();
    clk_step();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    for (int c = 0; c < 3; c++) begin
      if (c > 0) clk_step();
      rst_n = 1'b0;
      for (int i = 0; i < NREQ; i++) set_req(i, 1'b1, $urandom, $urandom);
      mst_resp.gnt = 1'b1; mst_resp.rvalid = 1'b1; mst_resp.rdata = $urandom;
      @(negedge clk);
      n_cmp++; if (mst_req.req !== 1'b0) begin n_err++; $display("FAIL reset_mreq c%0d: got %b expected 0", c, mst_req.req); end
      for (int i = 0; i < NREQ; i++) begin
        n_cmp++; if (slv_resp[i].gnt !== 1'b0 || slv_resp[i].rvalid !== 1'b0) begin
          n_err++; $display("FAIL reset_resp[%0d]: got gnt=%b rvalid=%b expected 0/0", i, slv_resp[i].gnt, slv_resp[i].rvalid); end
      end
    end
    clk_step();
    rst_n = 1'b1;
    drive_idle();
    set_req(0, 1'b0, 32'h0000_AAA0, 32'h0);
    set_req(1, 1'b0, 32'h0000_BBB0, 32'h0);
    @(negedge clk);
    n_cmp++; if (err !== 1'b0) begin n_err++; $display("FAIL reset_err: got %b expected 0", err); end
    n_cmp++; if (mst_req.req !== 1'b1 || mst_req.addr !== 32'h0000_AAA0) begin
      n_err++; $display("FAIL reset_rrptr: got req=%b addr=%h expected 1/0000aaa0", mst_req.req, mst_req.addr); end
  endtask

  task automatic test_single();
    int pulses;
    pulses = 0;
    apply_reset();
    for (int c = 0; c < 3; c++) begin
      clk_step();
      drive_idle();
      set_req(0, 1'b1, 32'h0000_0100, 32'hA5A5_0001);
      mst_resp.gnt = (c == 2);
      @(negedge clk);
      n_cmp++; if (mst_req.req !== 1'b1 || mst_req.addr !== 32'h0000_0100 || mst_req.we !== 1'b1) begin
        n_err++; $display("FAIL single_addr c%0d: got req=%b addr=%h we=%b expected 1/00000100/1", c, mst_req.req, mst_req.addr, mst_req.we); end
      n_cmp++; if (slv_resp[0].gnt !== (c == 2) || slv_resp[1].gnt !== 1'b0) begin
        n_err++; $display("FAIL single_gnt c%0d: got gnt0=%b gnt1=%b expected %0d/0", c, slv_resp[0].gnt, slv_resp[1].gnt, (c == 2)); end
      if (slv_resp[0].gnt === 1'b1) pulses++;
    end
    clk_step();
    drive_idle();
    @(negedge clk);
    if (slv_resp[0].gnt === 1'b1) pulses++;
    n_cmp++; if (mst_req.req !== 1'b0) begin n_err++; $display("FAIL single_idle: got req=%b expected 0", mst_req.req); end
    n_cmp++; if (pulses != 1) begin n_err++; $display("FAIL single_pulses: got %0d expected 1", pulses); end
    clk_step();
    mst_resp.rvalid = 1'b1; mst_resp.rdata = 32'h1234_5678;
    @(negedge clk);
    n_cmp++; if (slv_resp[0].rvalid !== 1'b1 || slv_resp[0].rdata !== 32'h1234_5678 || slv_resp[1].rvalid !== 1'b0) begin
      n_err++; $display("FAIL single_rvalid: got rv0=%b rdata=%h rv1=%b expected 1/12345678/0", slv_resp[0].rvalid, slv_resp[0].rdata, slv_resp[1].rvalid); end
    clk_step();
    drive_idle();
    @(negedge clk);
    n_cmp++; if (err !== 1'b0 || slv_resp[0].rvalid !== 1'b0) begin
      n_err++; $display("FAIL single_after: got err=%b rv0=%b expected 0/0", err, slv_resp[0].rvalid); end
  endtask

  task automatic test_alternate();
    int s, h;
    logic [31:0] rd;
    apply_reset();
    for (int k = 0; k <= 8; k++) begin
      clk_step();
      drive_idle();
      h  = (k - 1) % 2;
      rd = (h == 1) ? 32'hDEAD_BEEF : 32'h0000_0A00 + 32'(k);
      if (k < 8) begin
        set_req(0, 1'b0, 32'h0000_1000, 32'h0);
        set_req(1, 1'b1, 32'h0000_2000, 32'h1111_2222);
        mst_resp.gnt = 1'b1;
      end
      if (k >= 1) begin mst_resp.rvalid = 1'b1; mst_resp.rdata = rd; end
      @(negedge clk);
      if (k < 8) begin
        s = k % 2;
        n_cmp++; if (slv_resp[s].gnt !== 1'b1 || slv_resp[1-s].gnt !== 1'b0 || mst_req.addr !== (s == 1 ? 32'h2000 : 32'h1000)) begin
          n_err++; $display("FAIL alt_gnt k%0d: got gnt0=%b gnt1=%b addr=%h expected winner %0d", k, slv_resp[0].gnt, slv_resp[1].gnt, mst_req.addr, s); end
      end
      if (k >= 1) begin
        n_cmp++; if (slv_resp[h].rvalid !== 1'b1 || slv_resp[h].rdata !== rd || slv_resp[1-h].rvalid !== 1'b0) begin
          n_err++; $display("FAIL alt_route k%0d: got rv0=%b rv1=%b rdata=%h expected rv to %0d rdata %h", k, slv_resp[0].rvalid, slv_resp[1].rvalid, slv_resp[h].rdata, h, rd); end
      end
    end
  endtask

  task automatic test_lock();
    apply_reset();
    clk_step();
    drive_idle(); set_req(0, 1'b0, 32'h50, 32'h0); mst_resp.gnt = 1'b1;
    @(negedge clk);
    n_cmp++; if (slv_resp[0].gnt !== 1'b1) begin n_err++; $display("FAIL lock_pre_gnt: got %b expected 1", slv_resp[0].gnt); end
    clk_step();
    drive_idle(); mst_resp.rvalid = 1'b1; mst_resp.rdata = 32'h11;
    @(negedge clk);
    n_cmp++; if (slv_resp[0].rvalid !== 1'b1) begin n_err++; $display("FAIL lock_pre_rv: got %b expected 1", slv_resp[0].rvalid); end
    for (int c = 0; c < 5; c++) begin
      clk_step();
      drive_idle();
      set_req(0, 1'b1, 32'h0000_0200, 32'hC0DE_0000);
      if (c > 0) set_req(1, 1'b0, 32'h0000_0300, 32'h0);
      @(negedge clk);
      n_cmp++; if (mst_req.req !== 1'b1 || mst_req.addr !== 32'h200 || mst_req.wdata !== 32'hC0DE_0000 || mst_req.we !== 1'b1) begin
        n_err++; $display("FAIL lock_hold c%0d: got req=%b addr=%h wdata=%h expected 1/00000200/c0de0000", c, mst_req.req, mst_req.addr, mst_req.wdata); end
      n_cmp++; if (slv_resp[0].gnt !== 1'b0 || slv_resp[1].gnt !== 1'b0) begin
        n_err++; $display("FAIL lock_nogrant c%0d: got gnt0=%b gnt1=%b expected 0/0", c, slv_resp[0].gnt, slv_resp[1].gnt); end
    end
    clk_step();
    drive_idle();
    set_req(0, 1'b1, 32'h0000_0200, 32'hC0DE_0000); set_req(1, 1'b0, 32'h0000_0300, 32'h0); mst_resp.gnt = 1'b1;
    @(negedge clk);
    n_cmp++; if (slv_resp[0].gnt !== 1'b1 || slv_resp[1].gnt !== 1'b0) begin
      n_err++; $display("FAIL lock_release: got gnt0=%b gnt1=%b expected 1/0", slv_resp[0].gnt, slv_resp[1].gnt); end
    clk_step();
    drive_idle(); set_req(1, 1'b0, 32'h0000_0300, 32'h0); mst_resp.gnt = 1'b1;
    @(negedge clk);
    n_cmp++; if (slv_resp[1].gnt !== 1'b1 || mst_req.addr !== 32'h300) begin
      n_err++; $display("FAIL lock_next: got gnt1=%b addr=%h expected 1/00000300", slv_resp[1].gnt, mst_req.addr); end
    for (int r = 0; r < 2; r++) begin
      clk_step();
      drive_idle(); mst_resp.rvalid = 1'b1; mst_resp.rdata = 32'h22 + 32'(r);
      @(negedge clk);
      n_cmp++; if (slv_resp[r].rvalid !== 1'b1 || slv_resp[1-r].rvalid !== 1'b0 || slv_resp[r].rdata !== 32'h22 + 32'(r)) begin
        n_err++; $display("FAIL lock_route r%0d: got rv0=%b rv1=%b expected rv to %0d", r, slv_resp[0].rvalid, slv_resp[1].rvalid, r); end
    end
  endtask

  task automatic test_full();
    // per cycle: rvalid driven, expected gnt0
    bit rv_tab [12] = '{0,0,0,0, 0,0,1,0, 1,1,0,0};
    bit gn_tab [12] = '{1,1,1,1, 0,0,0,1, 0,1,1,0};
    apply_reset();
    for (int c = 0; c < 12; c++) begin
      clk_step();
      drive_idle();
      set_req(0, 1'b1, 32'h0000_0400 + 32'(c), 32'h0);
      mst_resp.gnt = 1'b1;
      mst_resp.rvalid = rv_tab[c]; mst_resp.rdata = 32'h4400 + 32'(c);
      @(negedge clk);
      n_cmp++; if (slv_resp[0].gnt !== gn_tab[c] || mst_req.req !== gn_tab[c]) begin
        n_err++; $display("FAIL full_gnt c%0d: got gnt0=%b mreq=%b expected %0d", c, slv_resp[0].gnt, mst_req.req, gn_tab[c]); end
      if (rv_tab[c]) begin
        n_cmp++; if (slv_resp[0].rvalid !== 1'b1) begin n_err++; $display("FAIL full_rv c%0d: got %b expected 1", c, slv_resp[0].rvalid); end
      end
    end
    for (int d = 0; d < 4; d++) begin
      clk_step();
      drive_idle(); mst_resp.rvalid = 1'b1; mst_resp.rdata = 32'h5500 + 32'(d);
      @(negedge clk);
      n_cmp++; if (slv_resp[0].rvalid !== 1'b1 || slv_resp[0].rdata !== 32'h5500 + 32'(d)) begin
        n_err++; $display("FAIL full_drain d%0d: got rv0=%b rdata=%h expected 1/%h", d, slv_resp[0].rvalid, slv_resp[0].rdata, 32'h5500 + 32'(d)); end
    end
    clk_step();
    drive_idle();
    @(negedge clk);
    n_cmp++; if (err !== 1'b0) begin n_err++; $display("FAIL full_err: got %b expected 0", err); end
  endtask

  task automatic test_unexpected();
    apply_reset();
    clk_step();
    drive_idle(); mst_resp.rvalid = 1'b1; mst_resp.rdata = 32'h99;
    @(negedge clk);
    n_cmp++; if (slv_resp[0].rvalid !== 1'b0 || slv_resp[1].rvalid !== 1'b0 || err !== 1'b0) begin
      n_err++; $display("FAIL unexp_rv: got rv0=%b rv1=%b err=%b expected 0/0/0", slv_resp[0].rvalid, slv_resp[1].rvalid, err); end
    for (int c = 0; c < 4; c++) begin
      clk_step();
      drive_idle();
      @(negedge clk);
      n_cmp++; if (err !== 1'b1) begin n_err++; $display("FAIL unexp_sticky c%0d: got %b expected 1", c, err); end
    end
    apply_reset();
    clk_step();
    @(negedge clk);
    n_cmp++; if (err !== 1'b0) begin n_err++; $display("FAIL unexp_clear: got %b expected 0", err); end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    for (int c = 0; c < 2; c++) begin
      clk_step();
      drive_idle();
      set_req(0, 1'b0, 32'h600, 32'h0); set_req(1, 1'b0, 32'h700, 32'h0); mst_resp.gnt = 1'b1;
      @(negedge clk);
      n_cmp++; if (slv_resp[c].gnt !== 1'b1) begin n_err++; $display("FAIL mid_gnt c%0d: got %b expected 1", c, slv_resp[c].gnt); end
    end
    clk_step();
    rst_n = 1'b0; drive_idle();
    clk_step();
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++; if (err !== 1'b0) begin n_err++; $display("FAIL mid_err_reset: got %b expected 0", err); end
`ifdef SAP_ARB_PERF_CNT_EN
    for (int i = 0; i < NREQ; i++) begin
      n_cmp++; if (gnt_cnt[i] !== 32'd0) begin n_err++; $display("FAIL mid_cnt[%0d]: got %0d expected 0", i, gnt_cnt[i]); end
    end
`endif
    for (int r = 0; r < 2; r++) begin
      clk_step();
      drive_idle(); mst_resp.rvalid = 1'b1; mst_resp.rdata = 32'h77;
      @(negedge clk);
      n_cmp++; if (slv_resp[0].rvalid !== 1'b0 || slv_resp[1].rvalid !== 1'b0) begin
        n_err++; $display("FAIL mid_rv r%0d: got rv0=%b rv1=%b expected 0/0", r, slv_resp[0].rvalid, slv_resp[1].rvalid); end
    end
    clk_step();
    drive_idle();
    @(negedge clk);
    n_cmp++; if (err !== 1'b1) begin n_err++; $display("FAIL mid_err: got %b expected 1", err); end
  endtask

  task automatic test_random();
    bit pend [NREQ];
    int s;
    bit em;
    apply_reset();
    for (int i = 0; i < NREQ; i++) pend[i] = 0;
    for (int c = 0; c < 600; c++) begin
      clk_step();
      for (int i = 0; i < NREQ; i++) begin
        if (!pend[i]) begin
          if ($urandom_range(0, 1) == 1) begin
            set_req(i, 1'($urandom), $urandom, $urandom);
            slv_req[i].be = 4'($urandom);
            pend[i] = 1;
          end else begin
            slv_req[i] = '0;
          end
        end
      end
      mst_resp.gnt    = ($urandom_range(0, 2) != 0);
      mst_resp.rvalid = (m_q.size() > 0) && ($urandom_range(0, 2) == 0);
      mst_resp.rdata  = $urandom;
      @(negedge clk);
      s  = m_sel();
      em = m_mreq();
      n_cmp++; if (mst_req.req !== em) begin n_err++; $display("FAIL rnd_mreq c%0d: got %b expected %b", c, mst_req.req, em); end
      if (em) begin
        n_cmp++; if ({mst_req.we, mst_req.be, mst_req.addr, mst_req.wdata} !== {slv_req[s].we, slv_req[s].be, slv_req[s].addr, slv_req[s].wdata}) begin
          n_err++; $display("FAIL rnd_fields c%0d: got addr=%h expected addr=%h from requester %0d", c, mst_req.addr, slv_req[s].addr, s); end
      end
      for (int i = 0; i < NREQ; i++) begin
        n_cmp++; if (slv_resp[i].gnt !== exp_gnt(i) || slv_resp[i].rvalid !== exp_rv(i)) begin
          n_err++; $display("FAIL rnd_resp[%0d] c%0d: got gnt=%b rv=%b expected %b/%b", i, c, slv_resp[i].gnt, slv_resp[i].rvalid, exp_gnt(i), exp_rv(i)); end
        if (exp_rv(i)) begin
          n_cmp++; if (slv_resp[i].rdata !== mst_resp.rdata) begin
            n_err++; $display("FAIL rnd_rdata[%0d] c%0d: got %h expected %h", i, c, slv_resp[i].rdata, mst_resp.rdata); end
        end
`ifdef SAP_ARB_PERF_CNT_EN
        n_cmp++; if (gnt_cnt[i] !== m_cnt[i]) begin n_err++; $display("FAIL rnd_cnt[%0d] c%0d: got %0d expected %0d", i, c, gnt_cnt[i], m_cnt[i]); end
`endif
      end
      n_cmp++; if (err !== m_err) begin n_err++; $display("FAIL rnd_err c%0d: got %b expected %b", c, err, m_err); end
      for (int i = 0; i < NREQ; i++) if (exp_gnt(i)) pend[i] = 0;
    end
  endtask

  initial begin
    rst_n = 1'b0;
    drive_idle();
    test_reset();
    test_single();
    test_alternate();
    test_lock();
    test_full();
    test_unexpected();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not reach the summary");
    $fatal(1);
  end

endmodule

// File: doc/sap_obi_ext_arbiter.md
Name: sap_obi_ext_arbiter

Overview:
- Round-robin arbiter that shares the single OBI external-master port of sap_top between NREQ OBI managers, e.g. the AXI→APB→OBI bridge path and a second on-chip manager (debug/DMA).
- Forwards one address phase at a time and holds the selection stable until it is granted.
- Tracks the order of outstanding transactions in a FIFO and routes each rvalid/rdata back to the requester that issued it.
- Sits between the bridge outputs and the ext_master port of sap_top inside the top wrapper.

Parameters:
- NREQ, 2, number of OBI managers (2..8).
- MAX_OUTSTANDING, 4, depth of the response-order FIFO (power of 2, ≥2).
- obi_req_t, logic, OBI request struct (fields req, we, be[3:0], addr[31:0], wdata[31:0]).
- obi_resp_t, logic, OBI response struct (fields gnt, rvalid, rdata[31:0]).

Ports:
- clk_i  in  1  clock; the only clock of the block.
- rst_ni  in  1  reset; synchronous, active-low.
- slv_req_i  in  obi_req_t[NREQ]  requests from the managers.
- slv_resp_o  out  obi_resp_t[NREQ]  responses to the managers.
- mst_req_o  out  obi_req_t  request to sap_top ext_master_req_i.
- mst_resp_i  in  obi_resp_t  response from sap_top ext_master_resp_o.
- err_o  out  1  sticky: rvalid received while the FIFO was empty.

Behaviour:
- Reset (rst_ni=0 at a clk_i edge): rr_ptr=0, lock=0, FIFO empty (count=0), err_o=0.
- While rst_ni is low, force mst_req_o.req=0 and all slv_resp_o gnt/rvalid to 0.
- Selection:
  - If lock=1, sel=lock_idx.
  - Otherwise sel is the first i with slv_req_i[i].req=1, searching from rr_ptr upward modulo NREQ.
  - Selection is combinational; there is zero added latency on the address phase.
- Masking: when count==MAX_OUTSTANDING, mst_req_o.req=0 and every gnt=0.
  - A pop in the same cycle does not unmask; full is evaluated on the registered count.
- Forwarding:
  - mst_req_o = slv_req_i[sel] when any request is present and the FIFO is not full; otherwise mst_req_o.req=0 and the other fields are don't-care.
  - slv_resp_o[sel].gnt = mst_resp_i.gnt; gnt=0 for every other requester.
- Lock:
  - If mst_req_o.req=1 and gnt=0, set lock=1 and lock_idx=sel; the address phase then stays stable to the subordinate.
  - Clear lock on handshake (req&gnt).
- Handshake (req&gnt):
  - Push sel into the FIFO.
  - Set rr_ptr=(sel+1) mod NREQ.
- Response phase:
  - rvalid arrives at least 1 cycle after gnt, in order.
  - On mst_resp_i.rvalid with the FIFO not empty: set slv_resp_o[head].rvalid=1 and rdata=mst_resp_i.rdata, then pop.
  - On rvalid with the FIFO empty: drop the response, no rvalid to any requester, set err_o=1 until reset.
- Simultaneous push and pop in one cycle: count unchanged; pointers wrap modulo MAX_OUTSTANDING.
- Reset mid-transaction: the FIFO is discarded. Late rvalids for pre-reset transactions set err_o.
- rdata of non-selected responses is don't-care (drive 0).
- Control FSM is two-state: ARB (lock=0) and HOLD (lock=1).
  - ARB→HOLD: req & !gnt.
  - HOLD→ARB: gnt.

Optional Feature:
- Macro SAP_ARB_PERF_CNT_EN.
- When defined, add an output gnt_cnt_o [NREQ][31:0]:
  - per-requester count of handshakes;
  - wraps at 2^32;
  - reset to 0;
  - increments in the cycle after the handshake.
- When not defined, the port and counters are absent and behaviour is otherwise identical.

Decomposition:
- Add to sap_pkg: localparam SAP_ARB_NREQ=2 and SAP_ARB_MAX_OUTST=4.
- Add to sap_pkg: typedef logic [$clog2(SAP_ARB_NREQ)-1:0] sap_arb_idx_t.
- One sub-module, sap_arb_order_fifo: a synchronous FIFO of sap_arb_idx_t with push, pop, full, empty and head outputs, and a sync active-low reset.
- Priority search, lock and routing stay in the top module.

Test Plan:
- Single requester: req0 write addr 0x0000_0100, gnt after 2 cycles.
  → mst addr stable for 3 cycles; gnt0 pulses once; a later rvalid reaches requester 0 only.
- Both requesters request continuously, subordinate gnt=1 every cycle.
  → grants alternate 0,1,0,1; requester 1 rdata 0xDEAD_BEEF is routed to requester 1.
- Lock: req0 pending with gnt=0 for 5 cycles while req1 also asserts.
  → mst_req_o holds requester 0's fields for all 5 cycles; requester 1 is granted next.
- Full: 4 grants with no rvalid, then a 5th request.
  → mst req=0 until the first rvalid, and the 5th request is granted the cycle after it.
  → Also check the same-cycle push+pop count when one is pending.
- Unexpected rvalid with the FIFO empty.
  → err_o=1 the next cycle and stays high; no slv rvalid; cleared only by rst_ni=0.
- Reset during 2 outstanding transactions, then 2 rvalids.
  → err_o=1 and no requester sees rvalid.
  → With SAP_ARB_PERF_CNT_EN, gnt_cnt_o=0 after reset.
